cpu_trace_checker: RTL and testbench
====================================

Name: cpu_trace_checker

Overview:
- Synthesizable, self-checking cycle-trace monitor for the accumulator CPU.
- Samples the CPU observation outputs every SAMPLE_DIV cycles, for DEPTH steps, after a programmable start delay.
- Compares each sample against a loaded expected-trace memory under a per-step care mask, counts mismatches and reports pass/fail.
- Replaces the fixed 5-step print loop with a parametrised, reusable checker that runs in simulation or on FPGA.

Parameters:
- PC_W, 5, width of PC and RAM address fields.
- DATA_W, 8, width of instruction, accumulator, RAM data and ALU result fields.
- DEPTH, 5, number of trace steps checked; ≥2.
- START_DELAY, 1, cycles spent in ARMED before the first sample; 0 skips ARMED.
- SAMPLE_DIV, 1, cycles between consecutive samples; ≥1.
- STOP_ON_ERR, 0, when 1 the first mismatch ends the run.
- ERR_W, 4, error-counter width; the counter saturates.
- Derived: IDX_W = max(1, clog2(DEPTH)); VEC_W = 2*PC_W + 4*DATA_W + 4 (46 with defaults).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin a run; single-cycle pulse.
- exp_we_i  in  1  write an expected-trace entry.
- exp_addr_i  in  IDX_W  entry index.
- exp_data_i  in  VEC_W  expected vector.
- exp_mask_i  in  VEC_W  care mask; 1 = compare this bit.
- obs_pc_i  in  PC_W  CPU current PC.
- obs_ins_i  in  DATA_W  current instruction.
- obs_wr_i  in  1  accumulator write enable.
- obs_acc_i  in  DATA_W  accumulator.
- obs_wm_i  in  1  RAM write enable.
- obs_addr_i  in  PC_W  RAM address.
- obs_ram_i  in  DATA_W  RAM bus.
- obs_alu_i  in  DATA_W  ALU result.
- obs_sw_i  in  2  flags; bit1 = C, bit0 = Z.
- busy_o  out  1  high in ARMED or RUN.
- done_o  out  1  run finished.
- pass_o  out  1  run finished with zero errors over all DEPTH steps.
- err_o  out  1  one-cycle pulse per mismatching sample.
- err_cnt_o  out  ERR_W  saturating mismatch count.
- first_err_valid_o  out  1  first_err_idx_o holds a valid index.
- first_err_idx_o  out  IDX_W  step index of the first mismatch.
- diff_o  out  VEC_W  (obs ^ exp) & mask of the most recent mismatch.
- step_o  out  IDX_W  next step index to be sampled.

Behaviour:
- Observation vector packing, MSB→LSB: pc, ins, wr, acc, wm, addr, ram, alu, C, Z.
- Reset: state IDLE; every output 0. Expected/mask memory (DEPTH×2×VEC_W) is not reset and is retained across reset.
- Load:
  - exp_we_i is honoured only in IDLE or DONE; it is ignored in ARMED and RUN.
  - exp_addr_i ≥ DEPTH is ignored.
  - A write takes effect at the clock edge.
- Start:
  - start_i in IDLE or DONE clears err_cnt, first_err_*, diff, step, done and pass.
  - It then enters ARMED, or RUN directly if START_DELAY = 0.
  - start_i in ARMED or RUN is ignored.
  - start_i and exp_we_i in the same cycle are both honoured.
- ARMED: lasts exactly START_DELAY cycles, then RUN.
- RUN sampling:
  - The first sample is taken on the first RUN cycle; further samples follow every SAMPLE_DIV cycles, driven by an internal divider.
  - On a sample: mism = |((obs ^ mem_exp[step]) & mem_mask[step]).
- Result registration, one cycle after the sample edge:
  - On mismatch: err_o pulses for 1 cycle; err_cnt increments and saturates at 2^ERR_W − 1; diff_o updates.
  - On the first mismatch of a run: first_err_idx_o = step and first_err_valid_o = 1.
  - On match: diff_o holds its previous value.
  - step increments after every sample.
- Termination:
  - The sample at step DEPTH−1 moves the checker to DONE; step_o saturates at DEPTH−1.
  - With STOP_ON_ERR = 1, any mismatch moves the checker to DONE and pass_o = 0.
- DONE: done_o = 1, busy_o = 0, and pass_o = (err_cnt == 0). Outputs hold until the next start or reset.
- Reset mid-run: immediate return to IDLE with outputs cleared.

Test Plan:
1. DEPTH=5, START_DELAY=1, SAMPLE_DIV=1. Load 5 vectors equal to the CPU stub's trace with all-ones masks, pulse start → busy_o high for 6 cycles; done_o=1, pass_o=1, err_cnt_o=0, first_err_valid_o=0.
2. Same setup, but entry 2 expects acc=0x05 while the CPU shows 0x07 → err_o pulses once; err_cnt_o=1, first_err_idx_o=2, diff_o has only acc bits [1] set (0x02 at the acc field); pass_o=0; run completes all 5 steps.
3. Mask: as scenario 2, but entry 2 mask clears the acc field → pass_o=1, err_cnt_o=0.
4. STOP_ON_ERR=1, mismatches at steps 1 and 3 → done_o asserts 1 cycle after the step-1 sample; err_cnt_o=1, first_err_idx_o=1, step_o=2.
5. SAMPLE_DIV=3, START_DELAY=0, ERR_W=2, all 5 steps mismatch → samples on RUN cycles 0, 3, 6, 9, 12; err_cnt_o saturates at 3; done_o at cycle 13.
6. Reset asserted during RUN step 2 → all outputs 0 next cycle; an exp_we_i issued during RUN is ignored; a re-start without reloading gives pass_o=1, proving memory retention.

Source files
------------

// File: rtl/cpu_trace_checker.sv
// Cycle-trace monitor for the accumulator CPU: samples the observation bus on a
// divided strobe and compares each sample with a loaded expected vector under a care mask.
module cpu_trace_checker #(
  parameter  int PC_W        = 5,
  parameter  int DATA_W      = 8,
  parameter  int DEPTH       = 5,
  parameter  int START_DELAY = 1,
  parameter  int SAMPLE_DIV  = 1,
  parameter  int STOP_ON_ERR = 0,
  parameter  int ERR_W       = 4,
  localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int VEC_W       = 2*PC_W + 4*DATA_W + 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              exp_we_i,
  input  logic [IDX_W-1:0]  exp_addr_i,
  input  logic [VEC_W-1:0]  exp_data_i,
  input  logic [VEC_W-1:0]  exp_mask_i,
  input  logic [PC_W-1:0]   obs_pc_i,
  input  logic [DATA_W-1:0] obs_ins_i,
  input  logic              obs_wr_i,
  input  logic [DATA_W-1:0] obs_acc_i,
  input  logic              obs_wm_i,
  input  logic [PC_W-1:0]   obs_addr_i,
  input  logic [DATA_W-1:0] obs_ram_i,
  input  logic [DATA_W-1:0] obs_alu_i,
  input  logic [1:0]        obs_sw_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              err_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic              first_err_valid_o,
  output logic [IDX_W-1:0]  first_err_idx_o,
  output logic [VEC_W-1:0]  diff_o,
  output logic [IDX_W-1:0]  step_o
);

  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [VEC_W-1:0] mem_exp  [DEPTH];
  logic [VEC_W-1:0] mem_mask [DEPTH];

  logic [DLY_W-1:0] dly_q, dly_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] step_q, step_d, idx_q, idx_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] diff_q, diff_d;
  logic             fev_q, fev_d, err_q, err_d, pass_q, pass_d;

  logic [VEC_W-1:0] obs, diffv;
  logic             idle_like, go, sample, mism, last, we_ok;

  assign obs = {obs_pc_i, obs_ins_i, obs_wr_i, obs_acc_i, obs_wm_i,
                obs_addr_i, obs_ram_i, obs_alu_i, obs_sw_i};

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign go        = idle_like && start_i;
  assign sample    = (state_q == S_RUN) && (div_q == '0);
  assign diffv     = (obs ^ mem_exp[step_q]) & mem_mask[step_q];
  assign mism      = |diffv;
  assign last      = (step_q == IDX_LAST);
  assign we_ok     = idle_like && exp_we_i && ({1'b0, exp_addr_i} < (IDX_W+1)'(DEPTH));

  // Trace memory is deliberately outside reset so a loaded trace survives it.
  always_ff @(posedge clk_i) begin
    if (we_ok) begin
      mem_exp[exp_addr_i]  <= exp_data_i;
      mem_mask[exp_addr_i] <= exp_mask_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = (START_DELAY == 0) ? S_RUN : S_ARMED;
      S_ARMED:        if (dly_q == DLY_LAST) state_d = S_RUN;
      S_RUN:          if (sample && (last || (STOP_ON_ERR != 0 && mism))) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == S_ARMED) || (state_q == S_RUN);
    done_o = (state_q == S_DONE);
  end

  always_comb begin
    dly_d  = dly_q;
    div_d  = div_q;
    step_d = step_q;
    cnt_d  = cnt_q;
    fev_d  = fev_q;
    idx_d  = idx_q;
    diff_d = diff_q;
    pass_d = pass_q;
    err_d  = 1'b0;
    if (go) begin
      dly_d  = '0;
      div_d  = '0;
      step_d = '0;
      cnt_d  = '0;
      fev_d  = 1'b0;
      idx_d  = '0;
      diff_d = '0;
      pass_d = 1'b0;
    end else begin
      if (state_q == S_ARMED) dly_d = dly_q + 1'b1;
      if (state_q == S_RUN) begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (sample) begin
          if (!last) step_d = step_q + 1'b1;
          if (mism) begin
            err_d  = 1'b1;
            diff_d = diffv;
            if (cnt_q != {ERR_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            if (!fev_q) begin
              fev_d = 1'b1;
              idx_d = step_q;
            end
          end
          // Saturating counter never wraps to zero, so this is exact.
          if (state_d == S_DONE) pass_d = (cnt_d == '0);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dly_q  <= '0;
      div_q  <= '0;
      step_q <= '0;
      cnt_q  <= '0;
      fev_q  <= 1'b0;
      idx_q  <= '0;
      diff_q <= '0;
      pass_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dly_q  <= dly_d;
      div_q  <= div_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
      fev_q  <= fev_d;
      idx_q  <= idx_d;
      diff_q <= diff_d;
      pass_q <= pass_d;
      err_q  <= err_d;
    end
  end

  assign pass_o            = pass_q;
  assign err_o             = err_q;
  assign err_cnt_o         = cnt_q;
  assign first_err_valid_o = fev_q;
  assign first_err_idx_o   = idx_q;
  assign diff_o            = diff_q;
  assign step_o            = step_q;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed bench: three checker instances (default, stop-on-error, divided sampling)
// share one observation bus driven from a hand-written CPU trace table.
module tb_cpu_trace_checker;
  localparam int VW = 46;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [2:0]    start_v, we_v;
  logic [2:0]    addr;
  logic [VW-1:0] edata, emask, obsv;

  logic [4:0] o_pc, o_addr;
  logic [7:0] o_ins, o_acc, o_ram, o_alu;
  logic       o_wr, o_wm;
  logic [1:0] o_sw;
  assign {o_pc, o_ins, o_wr, o_acc, o_wm, o_addr, o_ram, o_alu, o_sw} = obsv;

  logic [2:0]    busy_w, done_w, pass_w, err_w, fev_w;
  logic [3:0]    cnt0, cnt1;
  logic [1:0]    cnt2;
  logic [2:0]    idx0, idx1, idx2, step0, step1, step2;
  logic [VW-1:0] diff0, diff1, diff2;

  cpu_trace_checker u0 (
    .clk_i(clk), .reset_i(rst), .start_i(start_v[0]), .exp_we_i(we_v[0]),
    .exp_addr_i(addr), .exp_data_i(edata), .exp_mask_i(emask),
    .obs_pc_i(o_pc), .obs_ins_i(o_ins), .obs_wr_i(o_wr), .obs_acc_i(o_acc),
    .obs_wm_i(o_wm), .obs_addr_i(o_addr), .obs_ram_i(o_ram), .obs_alu_i(o_alu),
    .obs_sw_i(o_sw), .busy_o(busy_w[0]), .done_o(done_w[0]), .pass_o(pass_w[0]),
    .err_o(err_w[0]), .err_cnt_o(cnt0), .first_err_valid_o(fev_w[0]),
    .first_err_idx_o(idx0), .diff_o(diff0), .step_o(step0));

  cpu_trace_checker #(.STOP_ON_ERR(1)) u1 (
    .clk_i(clk), .reset_i(rst), .start_i(start_v[1]), .exp_we_i(we_v[1]),
    .exp_addr_i(addr), .exp_data_i(edata), .exp_mask_i(emask),
    .obs_pc_i(o_pc), .obs_ins_i(o_ins), .obs_wr_i(o_wr), .obs_acc_i(o_acc),
    .obs_wm_i(o_wm), .obs_addr_i(o_addr), .obs_ram_i(o_ram), .obs_alu_i(o_alu),
    .obs_sw_i(o_sw), .busy_o(busy_w[1]), .done_o(done_w[1]), .pass_o(pass_w[1]),
    .err_o(err_w[1]), .err_cnt_o(cnt1), .first_err_valid_o(fev_w[1]),
    .first_err_idx_o(idx1), .diff_o(diff1), .step_o(step1));

  cpu_trace_checker #(.SAMPLE_DIV(3), .START_DELAY(0), .ERR_W(2)) u2 (
    .clk_i(clk), .reset_i(rst), .start_i(start_v[2]), .exp_we_i(we_v[2]),
    .exp_addr_i(addr), .exp_data_i(edata), .exp_mask_i(emask),
    .obs_pc_i(o_pc), .obs_ins_i(o_ins), .obs_wr_i(o_wr), .obs_acc_i(o_acc),
    .obs_wm_i(o_wm), .obs_addr_i(o_addr), .obs_ram_i(o_ram), .obs_alu_i(o_alu),
    .obs_sw_i(o_sw), .busy_o(busy_w[2]), .done_o(done_w[2]), .pass_o(pass_w[2]),
    .err_o(err_w[2]), .err_cnt_o(cnt2), .first_err_valid_o(fev_w[2]),
    .first_err_idx_o(idx2), .diff_o(diff2), .step_o(step2));

  int nvec = 0, nerr = 0;
  logic [VW-1:0] trc [5];
  logic [VW-1:0] ones, acc2, accm;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pk(int pc, int ins, int wr, int acc, int wm,
                                       int ad, int ram, int alu, int sw);
    return {5'(pc), 8'(ins), 1'(wr), 8'(acc), 1'(wm), 5'(ad), 8'(ram), 8'(alu), 2'(sw)};
  endfunction

  task automatic ld(input logic [2:0] which, input int a, input logic [VW-1:0] d,
                    input logic [VW-1:0] m);
    @(negedge clk);
    we_v = which; addr = 3'(a); edata = d; emask = m;
    @(negedge clk);
    we_v = '0;
  endtask

  // Cycle c counts from the first cycle after the start edge; obs follows the
  // sample schedule: run cycle k = c - dly shows trace entry k / div.
  task automatic run(input int id, input int dly, input int div,
                     output int busy_n, output int done_at, output int errp);
    int k;
    busy_n = 0; done_at = -1; errp = 0;
    @(negedge clk);
    start_v[id] = 1'b1;
    @(negedge clk);
    start_v[id] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      k = c - dly;
      obsv = (k >= 0 && k / div < 5) ? trc[k / div] : '0;
      if (busy_w[id]) busy_n++;
      if (err_w[id]) errp++;
      if (done_w[id]) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  int bn, da, ep;

  initial begin
    rst = 1'b1; start_v = '0; we_v = '0; addr = '0; edata = '0; emask = '0; obsv = '0;
    ones = '1;
    acc2 = 46'h2 << 24;
    accm = 46'hFF << 24;
    trc[0] = pk(0, 'h1E, 0, 'h00, 0, 'h0E, 'h03, 'h03, 1);
    trc[1] = pk(1, 'h1E, 1, 'h03, 0, 'h0E, 'h03, 'h03, 0);
    trc[2] = pk(2, 'h2F, 1, 'h07, 0, 'h0F, 'h04, 'h07, 0);
    trc[3] = pk(3, 'h3D, 0, 'h07, 1, 'h0D, 'h07, 'h07, 0);
    trc[4] = pk(4, 'h00, 0, 'h07, 0, 'h00, 'h00, 'h07, 2);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy", 64'(busy_w[0]), 0);
    chk("rst_done", 64'(done_w[0]), 0);
    chk("rst_pass", 64'(pass_w[0]), 0);
    chk("rst_cnt",  64'(cnt0), 0);
    chk("rst_diff", 64'(diff0), 0);
    chk("rst_step", 64'(step0), 0);

    for (int i = 0; i < 5; i++) ld(3'b111, i, trc[i], ones);
    ld(3'b111, 6, '0, '0);  // out of range, must be dropped

    // clean trace
    run(0, 1, 1, bn, da, ep);
    chk("t1_busy",  64'(bn), 6);
    chk("t1_done",  64'(da), 6);
    chk("t1_pass",  64'(pass_w[0]), 1);
    chk("t1_cnt",   64'(cnt0), 0);
    chk("t1_fev",   64'(fev_w[0]), 0);
    chk("t1_step",  64'(step0), 4);
    chk("t1_errp",  64'(ep), 0);

    // acc mismatch at step 2
    ld(3'b001, 2, trc[2] ^ acc2, ones);
    run(0, 1, 1, bn, da, ep);
    chk("t2_errp", 64'(ep), 1);
    chk("t2_cnt",  64'(cnt0), 1);
    chk("t2_fev",  64'(fev_w[0]), 1);
    chk("t2_idx",  64'(idx0), 2);
    chk("t2_diff", 64'(diff0), 64'(acc2));
    chk("t2_pass", 64'(pass_w[0]), 0);
    chk("t2_done", 64'(da), 6);

    // same mismatch, acc field masked off
    ld(3'b001, 2, trc[2] ^ acc2, ~accm);
    run(0, 1, 1, bn, da, ep);
    chk("t3_pass", 64'(pass_w[0]), 1);
    chk("t3_cnt",  64'(cnt0), 0);
    chk("t3_diff", 64'(diff0), 0);

    // stop on first error
    ld(3'b010, 1, trc[1] ^ acc2, ones);
    ld(3'b010, 3, trc[3] ^ acc2, ones);
    run(1, 1, 1, bn, da, ep);
    chk("t4_done", 64'(da), 3);
    chk("t4_cnt",  64'(cnt1), 1);
    chk("t4_idx",  64'(idx1), 1);
    chk("t4_step", 64'(step1), 2);
    chk("t4_pass", 64'(pass_w[1]), 0);
    chk("t4_errp", 64'(ep), 1);

    // divided sampling, every step mismatches on Z, 2-bit counter
    for (int i = 0; i < 5; i++) ld(3'b100, i, trc[i] ^ 46'h1, ones);
    run(2, 0, 3, bn, da, ep);
    chk("t5_done", 64'(da), 13);
    chk("t5_busy", 64'(bn), 13);
    chk("t5_cnt",  64'(cnt2), 3);
    chk("t5_errp", 64'(ep), 5);
    chk("t5_idx",  64'(idx2), 0);
    chk("t5_diff", 64'(diff2), 1);
    chk("t5_pass", 64'(pass_w[2]), 0);

    // mid-run reset, write during RUN ignored, memory retained
    ld(3'b001, 2, trc[2], ones);
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; obsv = '0;
    @(negedge clk);
    obsv = trc[0]; we_v = 3'b001; addr = 3'd3; edata = trc[3] ^ 46'h1; emask = ones;
    @(negedge clk);
    we_v = '0; obsv = trc[1];
    @(negedge clk);
    chk("t6_step_mid", 64'(step0), 2);
    obsv = trc[2]; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", 64'(busy_w[0]), 0);
    chk("t6_step", 64'(step0), 0);
    chk("t6_outs", 64'({done_w[0], pass_w[0], err_w[0], fev_w[0], cnt0, idx0}), 0);
    chk("t6_diff", 64'(diff0), 0);
    run(0, 1, 1, bn, da, ep);
    chk("t6_pass", 64'(pass_w[0]), 1);
    chk("t6_cnt",  64'(cnt0), 0);
    chk("t6_doneat", 64'(da), 6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
